regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port among NUM_REQ writeback sources (e.g. EXU, LSU),
//   using round-robin arbitration with a valid/ready handshake per source.
//   Keeps a pending-write scoreboard (one bit per architectural register).
//   Decode uses the scoreboard to stall on RAW hazards and to block WAW issue.
//   Sits between the writeback sources and the register file's wen/waddr/wdata port.
// PARAMETERS
//   ADDR_WIDTH  5   register address width; 2**ADDR_WIDTH registers
//   DATA_WIDTH  32  register data width
//   NUM_REQ     2   number of writeback requesters, >= 2
// PORTS
//   clk          in   1                     clock, rising edge
//   rst_n        in   1                     reset, asynchronous, active-low
//   req_valid    in   NUM_REQ               per-source write request
//   req_ready    out  NUM_REQ               per-source grant; handshake = valid & ready
//   req_addr     in   NUM_REQ*ADDR_WIDTH    per-source dest reg; source i uses bits [i*AW +: AW]
//   req_data     in   NUM_REQ*DATA_WIDTH    per-source write data; source i uses bits [i*DW +: DW]
//   issue_valid  in   1                     decode issues an instruction that writes issue_addr
//   issue_addr   in   ADDR_WIDTH            destination register of the issuing instruction
//   issue_ready  out  1                     0 when issue_addr already pending (WAW block)
//   raddr1       in   ADDR_WIDTH            scoreboard query address 1 (rs1)
//   rs1_busy     out  1                     pending[raddr1]
//   raddr2       in   ADDR_WIDTH            scoreboard query address 2 (rs2)
//   rs2_busy     out  1                     pending[raddr2]
//   rf_wen       out  1                     register file write enable (registered)
//   rf_waddr     out  ADDR_WIDTH            register file write address (registered)
//   rf_wdata     out  DATA_WIDTH            register file write data (registered)
// BEHAVIOUR
//   Reset (rst_n low, async)
//   - rf_wen=0, rf_waddr=0, rf_wdata=0, all pending bits=0, RR pointer=0.
//   - req_ready=0 and issue_ready=0 while rst_n is low.
//   Arbitration
//   - Combinational; at most one grant per cycle. Search starts at pointer ptr and wraps.
//   - The first i with req_valid[i]=1 gets req_ready[i]=1; all other readys are 0.
//   - After a grant to i: ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
//   - req_ready never depends on its own req_valid being held; the output stage drains every
//     cycle, so throughput is 1 write/cycle.
//   Output stage
//   - A grant in cycle N puts rf_wen=1 with the granted addr/data in cycle N+1 (latency 1).
//   - rf_wen is high for exactly one cycle per grant.
//   - With no grant, rf_wen=0 and rf_waddr/rf_wdata hold their last value.
//   - A grant with addr 0 is accepted (req_ready=1) and dropped: rf_wen stays 0.
//   Scoreboard
//   - issue_valid & issue_ready & issue_addr!=0 sets pending[issue_addr] at the edge.
//   - issue_addr==0 never sets a bit. issue_ready = ~pending[issue_addr] (1 for addr 0).
//   - rf_wen=1 clears pending[rf_waddr] at the end of that cycle (the edge at which the
//     register file captures the data).
//   - Same-edge set and clear of the same address: set wins (newer producer).
//   - A write to a non-pending register is legal; it is performed and pending is unchanged.
//   - rs1_busy/rs2_busy: combinational read of pending, 0 for address 0.
//   - No bypass: a register is still busy in the cycle its rf_wen is high.
//   Reset mid-operation
//   - An in-flight output write is discarded (rf_wen=0 immediately); all pending bits are cleared.
// TESTING
//   1 Reset: hold rst_n=0 for 3 cycles, then release
//     -> rf_wen=0, rf_waddr=0, rs1_busy=rs2_busy=0 for every raddr, issue_ready=1.
//   2 Single: req_valid=01, req_addr[0]=5, req_data[0]=0xDEADBEEF
//     -> req_ready=01 in the same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF;
//        rf_wen=0 the cycle after.
//   3 Contention: req_valid=11 held for 4 cycles, addrs 1/2
//     -> grants 0,1,0,1; rf_waddr 1,2,1,2 on consecutive cycles.
//   4 Scoreboard: issue 7 -> rs1_busy=1 at raddr1=7 next cycle, and issue of 7 sees issue_ready=0;
//     writeback 7 -> busy stays 1 while rf_wen=1, then 0 the following cycle.
//   5 Collision: issue_addr=3 in the same cycle rf_wen=1 with rf_waddr=3 -> pending[3]=1 afterward.
//   6 x0 and reset: issue 0 -> rs1_busy stays 0; request with addr 0 -> accepted, rf_wen stays 0;
//     pull rst_n low with regs 4 and 9 pending and a grant in flight
//     -> rf_wen=0 immediately, both pending bits cleared.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources,
// with a registered write stage and a pending-write scoreboard for RAW/WAW hazard checks.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_addr,
  output logic                          issue_ready,
  input  logic [ADDR_WIDTH-1:0]         raddr1,
  output logic                          rs1_busy,
  input  logic [ADDR_WIDTH-1:0]         raddr2,
  output logic                          rs2_busy,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [ADDR_WIDTH-1:0] src_addr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] src_data_s [NUM_REQ];
  logic [NUM_REQ-1:0]    grant_s;
  logic                  grant_any_s;
  logic [PW-1:0]         grant_idx_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  issue_fire_s;
  int unsigned           cand_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign src_addr_s[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign src_data_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting at ptr_q, wrapping at NUM_REQ.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_any_s = 1'b0;
    grant_idx_s = {PW{1'b0}};
    cand_s      = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_any_s && req_valid[PW'(cand_s)]) begin
        grant_any_s = 1'b1;
        grant_idx_s = PW'(cand_s);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign grant_addr_s = src_addr_s[grant_idx_s];
  assign grant_data_s = src_data_s[grant_idx_s];
  assign req_ready    = rst_n ? grant_s : {NUM_REQ{1'b0}};
  // x0 is never marked pending, so its bit stays 0 and it always reads idle.
  assign issue_ready  = rst_n & ~pending_q[issue_addr];
  assign issue_fire_s = issue_valid & issue_ready & (issue_addr != {ADDR_WIDTH{1'b0}});
  assign rs1_busy     = pending_q[raddr1];
  assign rs2_busy     = pending_q[raddr2];
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;

  // Next-state for pointer, write stage and scoreboard; set after clear so a new producer wins.
  always_comb begin
    ptr_d      = ptr_q;
    rf_wen_d   = grant_any_s & (grant_addr_s != {ADDR_WIDTH{1'b0}});
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pending_d  = pending_q;
    if (grant_any_s) begin
      if (int'(grant_idx_s) == NUM_REQ - 1) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = grant_idx_s + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    if (rf_wen_d) begin
      rf_waddr_d = grant_addr_s;
      rf_wdata_d = grant_data_s;
    end else begin
      rf_waddr_d = rf_waddr_q;
    end
    if (rf_wen_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (issue_fire_s) begin
      pending_d[issue_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= {PW{1'b0}};
      pending_q  <= {NREG{1'b0}};
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= {ADDR_WIDTH{1'b0}};
      rf_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the arbiter and scoreboard.
`timescale 1ns/10ps
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_addr = '0;
  logic            issue_ready;
  logic [AW-1:0]   raddr1 = '0;
  logic            rs1_busy;
  logic [AW-1:0]   raddr2 = '0;
  logic            rs2_busy;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .raddr1(raddr1), .rs1_busy(rs1_busy), .raddr2(raddr2), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: set of pending registers, round-robin pointer, last write.
  bit [31:0]     m_pend = '0;
  int            m_ptr = 0;
  bit            m_wen = 1'b0;
  bit [AW-1:0]   m_waddr = '0;
  bit [DW-1:0]   m_wdata = '0;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] src_addr(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] src_data(input int i);
    return req_data[i*DW +: DW];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0; m_ptr <= 0; m_wen <= 1'b0; m_waddr <= '0; m_wdata <= '0;
    end else begin
      if (m_wen) m_pend[m_waddr] <= 1'b0;
      if (issue_valid && issue_addr != 0 && !m_pend[issue_addr]) m_pend[issue_addr] <= 1'b1;
      if (m_grant() >= 0) begin
        m_ptr <= (m_grant() + 1) % N;
        if (src_addr(m_grant()) != 0) begin
          m_wen <= 1'b1; m_waddr <= src_addr(m_grant()); m_wdata <= src_data(m_grant());
        end else begin
          m_wen <= 1'b0;
        end
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int g;
      logic [N-1:0] er;
      g  = m_grant();
      er = '0;
      if (rst_n && g >= 0) er[g] = 1'b1;
      chk("m_req_ready", req_ready, er);
      chk("m_issue_ready", issue_ready, rst_n && !m_pend[issue_addr]);
      chk("m_rs1_busy", rs1_busy, m_pend[raddr1]);
      chk("m_rs2_busy", rs2_busy, m_pend[raddr2]);
      chk("m_rf_wen", rf_wen, m_wen);
      chk("m_rf_waddr", rf_waddr, m_waddr);
      chk("m_rf_wdata", rf_wdata, m_wdata);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req1(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = '0; req_valid[src] = 1'b1;
    req_addr[src*AW +: AW] = a;
    req_data[src*DW +: DW] = d;
  endtask

  initial begin
    // 1 reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    #0.5;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_issue_ready", issue_ready, 1'b1);
    for (int a = 0; a < 32; a++) begin
      raddr1 = AW'(a); raddr2 = AW'(31 - a);
      #0.1;
      chk("rst_busy", {rs1_busy, rs2_busy}, 2'b00);
    end
    raddr1 = '0; raddr2 = '0;
    step();

    // 2 single request
    req1(0, 5'd5, 32'hDEAD_BEEF);
    #0.5 chk("single_ready", req_ready, 2'b01);
    step(); req_valid = '0;
    #0.5;
    chk("single_wen", rf_wen, 1'b1);
    chk("single_waddr", rf_waddr, 5'd5);
    chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
    step();
    chk("single_wen_off", rf_wen, 1'b0);

    // bring pointer back to source 0
    req1(1, 5'd6, 32'h6666_6666);
    step(); req_valid = '0;

    // 3 contention
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h2222_2222, 32'h1111_1111};
    for (int c = 0; c < 4; c++) begin
      #0.5 chk("cont_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("cont_wen", rf_wen, 1'b1);
      chk("cont_waddr", rf_waddr, (c % 2 == 0) ? 5'd1 : 5'd2);
    end
    req_valid = '0;
    step();

    // 4 scoreboard
    issue_valid = 1'b1; issue_addr = 5'd7;
    #0.5 chk("sb_issue_ready0", issue_ready, 1'b1);
    step(); issue_valid = 1'b0; raddr1 = 5'd7;
    #0.5;
    chk("sb_busy_set", rs1_busy, 1'b1);
    chk("sb_waw_block", issue_ready, 1'b0);
    req1(0, 5'd7, 32'h0000_0777);
    step(); req_valid = '0;
    #0.5;
    chk("sb_wb_wen", rf_wen, 1'b1);
    chk("sb_busy_during_wb", rs1_busy, 1'b1);
    step();
    chk("sb_busy_clear", rs1_busy, 1'b0);

    // 5 collision: set and clear of x3 on the same edge
    req1(0, 5'd3, 32'h0000_0333);
    step(); req_valid = '0;
    issue_valid = 1'b1; issue_addr = 5'd3;
    #0.5 chk("coll_wen", {rf_wen, rf_waddr}, {1'b1, 5'd3});
    step(); issue_valid = 1'b0; raddr2 = 5'd3;
    #0.5 chk("coll_pending", rs2_busy, 1'b1);

    // 6 x0 handling
    issue_valid = 1'b1; issue_addr = 5'd0;
    step(); issue_valid = 1'b0; raddr1 = 5'd0;
    #0.5 chk("x0_busy", rs1_busy, 1'b0);
    req1(0, 5'd0, 32'h0BAD_0BAD);
    #0.5 chk("x0_ready", req_ready, 2'b01);
    step(); req_valid = '0;
    #0.5 chk("x0_wen", rf_wen, 1'b0);

    // 6 reset mid-operation
    issue_valid = 1'b1; issue_addr = 5'd4;
    step(); issue_addr = 5'd9;
    step(); issue_valid = 1'b0;
    req1(0, 5'd12, 32'h1212_1212);
    step(); req_valid = 2'b01;
    raddr1 = 5'd4; raddr2 = 5'd9;
    #0.5 chk("mid_pre", {rf_wen, rs1_busy, rs2_busy}, 3'b111);
    #0.5 rst_n = 1'b0;
    #0.5;
    chk("mid_rst_wen", rf_wen, 1'b0);
    chk("mid_rst_busy", {rs1_busy, rs2_busy}, 2'b00);
    chk("mid_rst_ready", {req_ready, issue_ready}, 3'b000);
    req_valid = '0;
    step(); step();
    rst_n = 1'b1;

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid   = N'($urandom_range(0, 3));
      req_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      req_data    = {$urandom, $urandom};
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 5'($urandom_range(0, 7));
      raddr1      = 5'($urandom_range(0, 7));
      raddr2      = 5'($urandom_range(0, 7));
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #0.5 chk("rnd_rst_wen", rf_wen, 1'b0);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    req_valid = '0; issue_valid = 1'b0;
    step(); step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
